// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset core. Each state drives the datapath
// muxes, enables and ALU controls. Memory states wait for mem_ready.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               overflow,
  input  logic               positive,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_ctl,
  output logic               ext_op,
  output logic [2:0]         reg_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t state_q, state_d;

  logic is_rtype, is_addu, is_subu, is_slt, is_jr, is_alu_r;
  logic is_addi, is_addiu, is_ori, is_lui, is_alu_i;
  logic [1:0] r_alu_ctl, i_alu_ctl;
  logic       i_ext_op;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_addu   = is_rtype && (funct == FN_ADDU);
  assign is_subu   = is_rtype && (funct == FN_SUBU);
  assign is_slt    = is_rtype && (funct == FN_SLT);
  assign is_jr     = is_rtype && (funct == FN_JR);
  assign is_alu_r  = is_addu || is_subu || is_slt;
  assign is_addi   = (opcode == OP_ADDI);
  assign is_addiu  = (opcode == OP_ADDIU);
  assign is_ori    = (opcode == OP_ORI);
  assign is_lui    = (opcode == OP_LUI);
  assign is_alu_i  = is_addi || is_addiu || is_ori || is_lui;

  // ALU controls shared by the EXEC states and ALU_WB, which re-drives them to keep flags valid
  assign r_alu_ctl = is_addu ? 2'b00 : 2'b01;
  assign i_alu_ctl = is_ori ? 2'b10 : (is_lui ? 2'b11 : 2'b00);
  assign i_ext_op  = is_addi || is_addiu;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state = STATE_W'(state_q);

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctl   = 2'b00;
    ext_op    = 1'b0;
    reg_src   = 3'b000;
    reg_dst   = 2'b00;
    pc_src    = 2'b00;
    illegal   = 1'b0;
    // Outputs stay quiet during a reset cycle so an interrupted access cannot commit
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
          if (is_alu_r)                                     state_d = EXEC_R;
          else if (is_jr || opcode == OP_J || opcode == OP_JAL) state_d = JUMP;
          else if (is_alu_i)                                state_d = EXEC_I;
          else if (opcode == OP_LW || opcode == OP_SW)      state_d = MEM_ADDR;
          else if (opcode == OP_BEQ)                        state_d = BRANCH;
          else begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_ctl   = r_alu_ctl;
          state_d   = ALU_WB;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctl   = i_alu_ctl;
          ext_op    = i_ext_op;
          state_d   = ALU_WB;
        end
        ALU_WB: begin
          alu_src_a = 1'b1;
          reg_write = 1'b1;
          if (is_rtype) begin
            alu_ctl = r_alu_ctl;
            reg_dst = 2'b01;
            if (is_slt) reg_src = positive ? 3'b010 : 3'b011;
          end else begin
            alu_src_b = 2'b10;
            alu_ctl   = i_alu_ctl;
            ext_op    = i_ext_op;
            // Signed overflow on addi flags $30 instead of writing rt
            if (is_addi && overflow) begin
              reg_dst = 2'b10;
              reg_src = 3'b011;
            end
          end
          state_d = FETCH;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
          state_d   = (opcode == OP_SW) ? MEM_WR : (opcode == OP_LW) ? MEM_RD : FETCH;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = MEM_WB;
        end
        MEM_WB: begin
          reg_write = 1'b1;
          reg_src   = 3'b001;
          state_d   = FETCH;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) state_d = FETCH;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctl   = 2'b01;
          pc_src    = 2'b01;
          pc_write  = zero;
          state_d   = FETCH;
        end
        JUMP: begin
          pc_write = 1'b1;
          if (is_jr) pc_src = 2'b11;
          else       pc_src = 2'b10;
          if (opcode == OP_JAL) begin
            reg_write = 1'b1;
            reg_src   = 3'b100;
            reg_dst   = 2'b11;
          end
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instructions state by state and
// checks each cycle's controls against hand-derived values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, overflow, positive, mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_ctl, reg_dst, pc_src;
  logic       ext_op, illegal;
  logic [2:0] reg_src;
  logic [3:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .positive(positive), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
    .ext_op(ext_op), .reg_src(reg_src), .reg_dst(reg_dst), .pc_src(pc_src),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later
  task automatic apply_stimulus(input logic rst_v, input logic [5:0] op, input logic [5:0] fn,
                                input logic rdy);
    @(negedge clk);
    rst_n     = rst_v;
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; overflow = 1'b0; positive = 1'b0; mem_ready = 1'b0;

    apply_stimulus(1'b0, 6'h00, 6'h00, 1'b0);
    check_output("reset_state", 32'(state), 0);
    check_output("reset_mem_read_gated", 32'(mem_read), 0);

    apply_stimulus(1'b1, 6'h00, 6'h00, 1'b0);
    check_output("fetch_mem_read", 32'(mem_read), 1);
    check_output("fetch_wait_ir_write", 32'(ir_write), 0);
    check_output("fetch_alu_src_b", 32'(alu_src_b), 1);
    apply_stimulus(1'b1, 6'h00, 6'h21, 1'b1);
    check_output("fetch_hold_state", 32'(state), 0);
    check_output("fetch_ir_write", 32'(ir_write), 1);
    check_output("fetch_pc_write", 32'(pc_write), 1);

    // addu: 0,1,2,8,0
    apply_stimulus(1'b1, 6'h00, 6'h21, 1'b1);
    check_output("addu_decode_state", 32'(state), 1);
    check_output("addu_decode_alu_src_b", 32'(alu_src_b), 3);
    check_output("addu_decode_ext_op", 32'(ext_op), 1);
    apply_stimulus(1'b1, 6'h00, 6'h21, 1'b1);
    check_output("addu_exec_state", 32'(state), 2);
    check_output("addu_exec_alu_src_a", 32'(alu_src_a), 1);
    apply_stimulus(1'b1, 6'h00, 6'h21, 1'b1);
    check_output("addu_wb_state", 32'(state), 8);
    check_output("addu_wb_reg_write", 32'(reg_write), 1);
    check_output("addu_wb_reg_dst", 32'(reg_dst), 1);
    check_output("addu_wb_reg_src", 32'(reg_src), 0);
    check_output("addu_wb_alu_ctl", 32'(alu_ctl), 0);

    // addi: overflow redirects the write to $30
    apply_stimulus(1'b1, 6'h08, 6'h00, 1'b1);
    check_output("addi_fetch_state", 32'(state), 0);
    apply_stimulus(1'b1, 6'h08, 6'h00, 1'b1);
    apply_stimulus(1'b1, 6'h08, 6'h00, 1'b1);
    check_output("addi_exec_state", 32'(state), 3);
    check_output("addi_exec_ext_op", 32'(ext_op), 1);
    check_output("addi_exec_alu_src_b", 32'(alu_src_b), 2);
    overflow = 1'b1;
    apply_stimulus(1'b1, 6'h08, 6'h00, 1'b1);
    check_output("addi_ovf_state", 32'(state), 8);
    check_output("addi_ovf_reg_dst", 32'(reg_dst), 2);
    check_output("addi_ovf_reg_src", 32'(reg_src), 3);
    check_output("addi_ovf_reg_write", 32'(reg_write), 1);
    overflow = 1'b0;
    #1;
    check_output("addi_noovf_reg_dst", 32'(reg_dst), 0);
    check_output("addi_noovf_reg_src", 32'(reg_src), 0);

    // ori: zero-extended, OR
    apply_stimulus(1'b1, 6'h0D, 6'h00, 1'b1);
    apply_stimulus(1'b1, 6'h0D, 6'h00, 1'b1);
    apply_stimulus(1'b1, 6'h0D, 6'h00, 1'b1);
    check_output("ori_exec_alu_ctl", 32'(alu_ctl), 2);
    check_output("ori_exec_ext_op", 32'(ext_op), 0);
    apply_stimulus(1'b1, 6'h0D, 6'h00, 1'b1);

    // slt: result taken from the sign flag
    apply_stimulus(1'b1, 6'h00, 6'h2A, 1'b1);
    apply_stimulus(1'b1, 6'h00, 6'h2A, 1'b1);
    apply_stimulus(1'b1, 6'h00, 6'h2A, 1'b1);
    check_output("slt_exec_alu_ctl", 32'(alu_ctl), 1);
    positive = 1'b0;
    apply_stimulus(1'b1, 6'h00, 6'h2A, 1'b1);
    check_output("slt_neg_reg_src", 32'(reg_src), 3);
    positive = 1'b1;
    #1;
    check_output("slt_pos_reg_src", 32'(reg_src), 2);

    // lw with three wait cycles in MEM_RD: 8 cycles in total
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b1);
    check_output("lw_c1_state", 32'(state), 0);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b0);
    check_output("lw_c2_state", 32'(state), 1);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b0);
    check_output("lw_c3_state", 32'(state), 4);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 6'h23, 6'h00, 1'b0);
      check_output($sformatf("lw_wait%0d_state", i), 32'(state), 5);
      check_output($sformatf("lw_wait%0d_mem_read", i), 32'(mem_read), 1);
      check_output($sformatf("lw_wait%0d_i_or_d", i), 32'(i_or_d), 1);
    end
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b1);
    check_output("lw_c7_state", 32'(state), 5);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b1);
    check_output("lw_c8_state", 32'(state), 6);
    check_output("lw_wb_reg_src", 32'(reg_src), 1);
    check_output("lw_wb_reg_write", 32'(reg_write), 1);

    // beq taken then not taken, 3 cycles each
    zero = 1'b1;
    for (int t = 0; t < 2; t++) begin
      apply_stimulus(1'b1, 6'h04, 6'h00, 1'b1);
      check_output($sformatf("beq%0d_fetch_state", t), 32'(state), 0);
      apply_stimulus(1'b1, 6'h04, 6'h00, 1'b1);
      apply_stimulus(1'b1, 6'h04, 6'h00, 1'b1);
      check_output($sformatf("beq%0d_branch_state", t), 32'(state), 9);
      check_output($sformatf("beq%0d_pc_write", t), 32'(pc_write), (t == 0) ? 1 : 0);
      check_output($sformatf("beq%0d_pc_src", t), 32'(pc_src), 1);
      check_output($sformatf("beq%0d_alu_ctl", t), 32'(alu_ctl), 1);
      zero = 1'b0;
    end

    // jal
    apply_stimulus(1'b1, 6'h03, 6'h00, 1'b1);
    check_output("jal_fetch_state", 32'(state), 0);
    apply_stimulus(1'b1, 6'h03, 6'h00, 1'b1);
    apply_stimulus(1'b1, 6'h03, 6'h00, 1'b1);
    check_output("jal_state", 32'(state), 10);
    check_output("jal_pc_src", 32'(pc_src), 2);
    check_output("jal_reg_dst", 32'(reg_dst), 3);
    check_output("jal_reg_src", 32'(reg_src), 4);
    check_output("jal_reg_write", 32'(reg_write), 1);
    check_output("jal_pc_write", 32'(pc_write), 1);

    // jr
    apply_stimulus(1'b1, 6'h00, 6'h08, 1'b1);
    check_output("jr_fetch_state", 32'(state), 0);
    apply_stimulus(1'b1, 6'h00, 6'h08, 1'b1);
    apply_stimulus(1'b1, 6'h00, 6'h08, 1'b1);
    check_output("jr_state", 32'(state), 10);
    check_output("jr_pc_src", 32'(pc_src), 3);
    check_output("jr_reg_write", 32'(reg_write), 0);

    // undecoded opcode 3Fh
    apply_stimulus(1'b1, 6'h3F, 6'h00, 1'b1);
    check_output("ill_fetch_state", 32'(state), 0);
    apply_stimulus(1'b1, 6'h3F, 6'h00, 1'b1);
    check_output("ill_decode_state", 32'(state), 1);
    check_output("ill_pulse", 32'(illegal), 1);
    apply_stimulus(1'b1, 6'h3F, 6'h00, 1'b0);
    check_output("ill_back_state", 32'(state), 0);
    check_output("ill_cleared", 32'(illegal), 0);

    // sw interrupted by reset while waiting in MEM_WR
    apply_stimulus(1'b1, 6'h2B, 6'h00, 1'b1);
    apply_stimulus(1'b1, 6'h2B, 6'h00, 1'b1);
    apply_stimulus(1'b1, 6'h2B, 6'h00, 1'b0);
    check_output("sw_addr_state", 32'(state), 4);
    apply_stimulus(1'b1, 6'h2B, 6'h00, 1'b0);
    check_output("sw_wr_state", 32'(state), 7);
    check_output("sw_wr_mem_write", 32'(mem_write), 1);
    check_output("sw_wr_mem_read", 32'(mem_read), 0);
    apply_stimulus(1'b1, 6'h2B, 6'h00, 1'b0);
    check_output("sw_wait_mem_write", 32'(mem_write), 1);
    apply_stimulus(1'b0, 6'h2B, 6'h00, 1'b0);
    check_output("rst1_state", 32'(state), 7);
    check_output("rst1_mem_write", 32'(mem_write), 0);
    apply_stimulus(1'b0, 6'h2B, 6'h00, 1'b0);
    check_output("rst2_state", 32'(state), 0);
    check_output("rst2_mem_write", 32'(mem_write), 0);
    apply_stimulus(1'b1, 6'h2B, 6'h00, 1'b0);
    check_output("post_rst_state", 32'(state), 0);
    check_output("post_rst_mem_read", 32'(mem_read), 1);
    check_output("post_rst_mem_write", 32'(mem_write), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle FSM controller for the MIPS-subset core: addu, subu, slt, jr, ori, lui, addi, addiu, lw, sw, beq, j, jal.
- Replaces single-cycle decode with per-state control, so the datapath can share one ALU and one unified memory port.
- Sits between the IR/flag outputs of the datapath and its mux, write-enable and ALU controls.
- Memory accesses use a ready handshake, so the core tolerates variable-latency memory.

Parameters:
- STATE_W, 4, width of the state register and debug port.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU result==0, combinational from the current ALU inputs
- overflow  in  1  ALU signed overflow
- positive  in  1  ALU result >= 0 (signed)
- mem_ready  in  1  memory completed the access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A register
- alu_src_b  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
- alu_ctl  out  2  00=add, 01=sub, 10=or, 11=lui
- ext_op  out  1  1=sign-extend, 0=zero-extend
- reg_src  out  3  000=ALU, 001=MDR, 010=const 0, 011=const 1, 100=PC
- reg_dst  out  2  00=rt, 01=rd, 10=$30, 11=$31
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],imm26,00}, 11=A (rs)
- illegal  out  1  one-cycle pulse on an undecoded instruction
- state  out  STATE_W  current state, debug only

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9, JUMP=10. Codes 11-15 go to FETCH.
- Output style: Moore outputs plus flag/ready qualification. All enables and the illegal output default to 0. All selects default to 0 unless stated per state.
- Reset: when rst_n=0 at a clock edge, state=FETCH. This applies mid-instruction too: no write enable is asserted in the reset cycle, and outputs are gated by !rst_n.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=00.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise hold in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_ctl=00, ext_op=1. The datapath latches the branch target into ALUOut.
  - Next state:
    - R-type addu/subu/slt → EXEC_R; R-type jr → JUMP.
    - ori/lui/addi/addiu → EXEC_I.
    - lw/sw → MEM_ADDR.
    - beq → BRANCH.
    - j/jal → JUMP.
    - Anything else: illegal=1, go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00; alu_ctl=00 for addu, 01 for subu/slt; go to ALU_WB.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - alu_ctl: ori=10, lui=11, addi/addiu=00.
  - ext_op=1 for addi/addiu, 0 for ori/lui.
  - Go to ALU_WB.
- ALU_WB:
  - Re-drive this instruction's EXEC controls so the flags stay valid. reg_write=1.
  - R-type: reg_dst=01. slt: reg_src=011 if !positive, else 010. Others: reg_src=000.
  - I-type: reg_dst=00, reg_src=000.
  - addi with overflow=1: reg_dst=10, reg_src=011, i.e. $30 ← 1 and rt is not written.
  - Go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctl=00, ext_op=1. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to MEM_WB, else hold.
- MEM_WB: reg_write=1, reg_src=001, reg_dst=00; go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready go to FETCH, else hold. mem_write stays asserted for every cycle of the wait.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctl=01; pc_src=01; pc_write=zero; go to FETCH.
- JUMP:
  - j: pc_src=10.
  - jal: pc_src=10 plus reg_write=1, reg_src=100, reg_dst=11. This writes PC+4, since PC was already incremented in FETCH.
  - jr: pc_src=11.
  - pc_write=1; go to FETCH.
- Latency, excluding wait states: beq/j/jal/jr 3 cycles, ALU ops 4, sw 4, lw 5. Each mem_ready=0 cycle adds one cycle in FETCH, MEM_RD or MEM_WR.
- Invariants:
  - Never assert mem_read and mem_write together.
  - Never assert more than one of pc_write or ir_write outside FETCH.

Test Plan:
- rst_n=0 held 2 cycles during MEM_WR → state=0, mem_write=0 in the reset cycle. After release, FETCH with mem_read=1.
- addu (opcode 0, funct 21h), mem_ready=1 → states 0,1,2,8,0. In ALU_WB: reg_write=1, reg_dst=01, reg_src=000, alu_ctl=00.
- addi with overflow=1 in ALU_WB → reg_dst=10, reg_src=011, reg_write=1. With overflow=0 → reg_dst=00, reg_src=000.
- lw with mem_ready low for 3 cycles in MEM_RD → 8 cycles total, mem_read held, then MEM_WB with reg_src=001.
- beq with zero=1 → pc_write=1, pc_src=01 in BRANCH. With zero=0 → pc_write=0. Both take 3 cycles.
- jal → JUMP: pc_src=10, reg_dst=11, reg_src=100, reg_write=1. Opcode 3Fh → illegal pulses 1 cycle in DECODE, then FETCH.
